// File: rtl/fwd_hazard_unit.sv
// EX operand-select and stall/bubble control between the ID and EX stages of a 5-stage MIPS pipeline.
// Define FWD_HAZARD_FORWARD_EN to forward from EX/MEM and MEM/WB; otherwise any RAW hazard stalls.
module fwd_hazard_unit #(
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic       id_b_imm,
  input  logic       id_wr_en,
  input  logic [4:0] id_wd,
  input  logic       id_is_load,
  input  logic       id_is_muldiv,
  input  logic       flush,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       stall,
  output logic       ex_bubble
);

  typedef struct packed {
    logic       valid;
    logic       wr_en;
    logic [4:0] wd;
    logic       is_load;
  } shadow_t;

  typedef enum logic [1:0] {
    SEL_RF    = 2'b00,
    SEL_EXMEM = 2'b01,
    SEL_MEMWB = 2'b10,
    SEL_IMM   = 2'b11
  } sel_e;

  localparam logic [3:0] BUSY_LOAD = 4'(MULDIV_LAT - 1);

  shadow_t    ex_q, ex_d, mem_q, mem_d;
  sel_e       sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic       ex_bubble_q, ex_bubble_d;
  logic [3:0] busy_q, busy_d;

  logic ex_a_hit, ex_b_hit, mem_a_hit, mem_b_hit;
  logic load_use, busy, dep_stall, stall_c, advance;

  // $0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic src_match(input shadow_t st, input logic used, input logic [4:0] src);
    return used && (src != 5'd0) && st.valid && st.wr_en && (st.wd == src);
  endfunction

  always_comb begin
    ex_a_hit  = src_match(ex_q,  id_rs_used, id_rs);
    ex_b_hit  = src_match(ex_q,  id_rt_used, id_rt);
    mem_a_hit = src_match(mem_q, id_rs_used, id_rs);
    mem_b_hit = src_match(mem_q, id_rt_used, id_rt);
    load_use  = ex_q.is_load & (ex_a_hit | ex_b_hit);
    busy      = (busy_q != 4'd0);
`ifdef FWD_HAZARD_FORWARD_EN
    dep_stall = 1'b0;
`else
    dep_stall = ex_a_hit | ex_b_hit | mem_a_hit | mem_b_hit;
`endif
    // Flush kills the ID instruction, so it can never be the one held back.
    stall_c = id_valid & ~flush & (load_use | busy | dep_stall);
    advance = id_valid & ~flush & ~stall_c;
  end

  assign stall = stall_c;

  // NOTE: every next-state variable gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    mem_d       = ex_q;
    ex_d        = '0;
    sel_a_d     = SEL_RF;
    sel_b_d     = SEL_RF;
    ex_bubble_d = ~advance;
    busy_d      = busy ? busy_q - 4'd1 : busy_q;
    if (advance) begin
      ex_d.valid   = 1'b1;
      ex_d.wr_en   = id_wr_en;
      ex_d.wd      = id_wd;
      ex_d.is_load = id_is_load;
      if (id_is_muldiv) busy_d = BUSY_LOAD;
`ifdef FWD_HAZARD_FORWARD_EN
      // The EX writer is younger than the MEM writer, so it wins when both match.
      if (ex_a_hit)       sel_a_d = SEL_EXMEM;
      else if (mem_a_hit) sel_a_d = SEL_MEMWB;
      if (id_b_imm)       sel_b_d = SEL_IMM;
      else if (ex_b_hit)  sel_b_d = SEL_EXMEM;
      else if (mem_b_hit) sel_b_d = SEL_MEMWB;
`else
      if (id_b_imm)       sel_b_d = SEL_IMM;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      sel_a_q     <= SEL_RF;
      sel_b_q     <= SEL_RF;
      ex_bubble_q <= 1'b1;
      busy_q      <= 4'd0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      ex_bubble_q <= ex_bubble_d;
      busy_q      <= busy_d;
    end
  end

  assign fwd_a_sel = sel_a_q;
  assign fwd_b_sel = sel_b_q;
  assign ex_bubble = ex_bubble_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit; expectations follow FWD_HAZARD_FORWARD_EN
// so the same sequence covers both the forwarding and the stall-only build.
module tb_fwd_hazard_unit;

`ifdef FWD_HAZARD_FORWARD_EN
  localparam logic [1:0] S_EX        = 2'b01;
  localparam logic [1:0] S_MEM       = 2'b10;
  localparam int         EX_STALLS   = 0;
  localparam int         MEM_STALLS  = 0;
  localparam int         LOAD_EXTRA  = 0;
`else
  localparam logic [1:0] S_EX        = 2'b00;
  localparam logic [1:0] S_MEM       = 2'b00;
  localparam int         EX_STALLS   = 2;
  localparam int         MEM_STALLS  = 1;
  localparam int         LOAD_EXTRA  = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_b_imm, id_wr_en, id_is_load, id_is_muldiv, flush;
  logic [4:0] id_rs, id_rt, id_wd;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall, ex_bubble;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.MULDIV_LAT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_used  (id_rs_used),
    .id_rt_used  (id_rt_used),
    .id_b_imm    (id_b_imm),
    .id_wr_en    (id_wr_en),
    .id_wd       (id_wd),
    .id_is_load  (id_is_load),
    .id_is_muldiv(id_is_muldiv),
    .flush       (flush),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stall       (stall),
    .ex_bubble   (ex_bubble)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic rsu, input logic [4:0] rt, input logic rtu,
                       input logic imm, input logic we, input logic [4:0] wd, input logic ld,
                       input logic md);
    id_valid = 1'b1;
    id_rs = rs;  id_rs_used = rsu;
    id_rt = rt;  id_rt_used = rtu;
    id_b_imm = imm;  id_wr_en = we;  id_wd = wd;
    id_is_load = ld; id_is_muldiv = md;
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0;
    id_rs = '0; id_rs_used = 1'b0;
    id_rt = '0; id_rt_used = 1'b0;
    id_b_imm = 1'b0; id_wr_en = 1'b0; id_wd = '0;
    id_is_load = 1'b0; id_is_muldiv = 1'b0;
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  // Holds the current ID instruction until stall drops, bounded so a stuck stall still ends the run.
  task automatic count_stalls(input string tag, input int exp);
    int n;
    n = 0;
    while (stall === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    check(tag, n, exp);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_a_sel", fwd_a_sel, 2'b00);
    check("rst_b_sel", fwd_b_sel, 2'b00);
    check("rst_bubble", ex_bubble, 1'b1);
    check("rst_stall", stall, 1'b0);

    // add $3,$1,$2 ; sub $4,$3,$5
    drive(5'd1, 1, 5'd2, 1, 0, 1, 5'd3, 0, 0);
    check("add_stall", stall, 1'b0);
    tick();
    check("add_bubble", ex_bubble, 1'b0);
    drive(5'd3, 1, 5'd5, 1, 0, 1, 5'd4, 0, 0);
    count_stalls("sub_stalls", EX_STALLS);
    tick();
    check("sub_a_sel", fwd_a_sel, S_EX);
    check("sub_b_sel", fwd_b_sel, 2'b00);
    check("sub_bubble", ex_bubble, 1'b0);
    drain();

    // add $3 ; or $3,$4,$5 ; and $6,$3,$3 -> newest writer wins
    drive(5'd1, 1, 5'd2, 1, 0, 1, 5'd3, 0, 0);
    tick();
    drive(5'd4, 1, 5'd5, 1, 0, 1, 5'd3, 0, 0);
    check("or_stall", stall, 1'b0);
    tick();
    drive(5'd3, 1, 5'd3, 1, 0, 1, 5'd6, 0, 0);
    count_stalls("prio_stalls", EX_STALLS);
    tick();
    check("prio_a_sel", fwd_a_sel, S_EX);
    check("prio_b_sel", fwd_b_sel, S_EX);
    drain();

    // add $3 ; xor $9,$1,$2 ; and $6,$3,$0
    drive(5'd1, 1, 5'd2, 1, 0, 1, 5'd3, 0, 0);
    tick();
    drive(5'd1, 1, 5'd2, 1, 0, 1, 5'd9, 0, 0);
    tick();
    drive(5'd3, 1, 5'd0, 1, 0, 1, 5'd6, 0, 0);
    count_stalls("mem_stalls", MEM_STALLS);
    tick();
    check("mem_a_sel", fwd_a_sel, S_MEM);
    check("mem_b_sel", fwd_b_sel, 2'b00);
    drain();

    // lw $7,0($1) ; add $8,$7,$0 -> one load-use bubble
    drive(5'd1, 1, 5'd7, 0, 1, 1, 5'd7, 1, 0);
    check("lw_stall", stall, 1'b0);
    tick();
    check("lw_b_sel", fwd_b_sel, 2'b11);
    check("lw_a_sel", fwd_a_sel, 2'b00);
    drive(5'd7, 1, 5'd0, 1, 0, 1, 5'd8, 0, 0);
    check("lu_stall", stall, 1'b1);
    tick();
    check("lu_bubble", ex_bubble, 1'b1);
    check("lu_bub_a_sel", fwd_a_sel, 2'b00);
    count_stalls("lu_extra", LOAD_EXTRA);
    tick();
    check("lu_a_sel", fwd_a_sel, S_MEM);
    check("lu_enter", ex_bubble, 1'b0);
    drain();

    // lw $0 ; add $8,$0,$0 -> $0 never matches
    drive(5'd1, 1, 5'd0, 0, 1, 1, 5'd0, 1, 0);
    tick();
    drive(5'd0, 1, 5'd0, 1, 0, 1, 5'd8, 0, 0);
    check("r0_stall", stall, 1'b0);
    tick();
    check("r0_a_sel", fwd_a_sel, 2'b00);
    check("r0_b_sel", fwd_b_sel, 2'b00);
    check("r0_bubble", ex_bubble, 1'b0);
    drain();

    // add $3 ; addi $4,$3,imm with rt also matching -> immediate outranks forwarding
    drive(5'd1, 1, 5'd2, 1, 0, 1, 5'd3, 0, 0);
    tick();
    drive(5'd3, 1, 5'd3, 1, 1, 1, 5'd4, 0, 0);
    count_stalls("imm_stalls", EX_STALLS);
    tick();
    check("imm_a_sel", fwd_a_sel, S_EX);
    check("imm_b_sel", fwd_b_sel, 2'b11);
    drain();

    // mult ; add independent -> MULDIV_LAT-1 stalls
    drive(5'd1, 1, 5'd2, 1, 0, 0, 5'd0, 0, 1);
    check("mult_stall", stall, 1'b0);
    tick();
    drive(5'd9, 1, 5'd10, 1, 0, 1, 5'd8, 0, 0);
    check("mul_bubble_pre", ex_bubble, 1'b0);
    count_stalls("mul_stalls", 3);
    check("mul_bubble", ex_bubble, 1'b1);
    tick();
    check("mul_enter", ex_bubble, 1'b0);
    drain();

    // mult ; div ; add -> div waits for the counter, then add waits again
    drive(5'd1, 1, 5'd2, 1, 0, 0, 5'd0, 0, 1);
    tick();
    drive(5'd3, 1, 5'd4, 1, 0, 0, 5'd0, 0, 1);
    count_stalls("div_stalls", 3);
    tick();
    check("div_enter", ex_bubble, 1'b0);
    drive(5'd9, 1, 5'd10, 1, 0, 1, 5'd8, 0, 0);
    count_stalls("div_add_stalls", 3);
    drain();

    // Flush during a mul/div stall: stall drops, bubble inserted, counter keeps running
    drive(5'd1, 1, 5'd2, 1, 0, 0, 5'd0, 0, 1);
    tick();
    drive(5'd9, 1, 5'd10, 1, 0, 1, 5'd8, 0, 0);
    check("fl_pre_stall", stall, 1'b1);
    flush = 1'b1;
    #1;
    check("fl_stall", stall, 1'b0);
    tick();
    check("fl_bubble", ex_bubble, 1'b1);
    flush = 1'b0;
    #1;
    count_stalls("fl_busy_left", 2);
    drain();

    // Flush of a dependent instruction clears its selects
    drive(5'd1, 1, 5'd2, 1, 0, 1, 5'd3, 0, 0);
    tick();
    drive(5'd3, 1, 5'd5, 1, 1, 1, 5'd4, 0, 0);
    flush = 1'b1;
    #1;
    check("flh_stall", stall, 1'b0);
    tick();
    check("flh_a_sel", fwd_a_sel, 2'b00);
    check("flh_b_sel", fwd_b_sel, 2'b00);
    check("flh_bubble", ex_bubble, 1'b1);
    flush = 1'b0;
    drain();

    // Flushed mul/div never loads the counter
    drive(5'd1, 1, 5'd2, 1, 0, 0, 5'd0, 0, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(5'd9, 1, 5'd10, 1, 0, 1, 5'd8, 0, 0);
    check("flm_stall", stall, 1'b0);
    drain();

    // Reset during the busy count, with flush also high
    drive(5'd1, 1, 5'd2, 1, 0, 0, 5'd0, 0, 1);
    tick();
    drive(5'd1, 1, 5'd4, 0, 1, 1, 5'd4, 0, 0);
    rst = 1'b1;
    flush = 1'b1;
    tick();
    rst = 1'b0;
    flush = 1'b0;
    #1;
    check("rb_a_sel", fwd_a_sel, 2'b00);
    check("rb_b_sel", fwd_b_sel, 2'b00);
    check("rb_bubble", ex_bubble, 1'b1);
    check("rb_stall", stall, 1'b0);
    tick();
    check("rb_addi_b_sel", fwd_b_sel, 2'b11);
    check("rb_addi_bubble", ex_bubble, 1'b0);
    drain();

    // Reset clears the shadow pipeline: the former dependency disappears
    drive(5'd1, 1, 5'd2, 1, 0, 1, 5'd3, 0, 0);
    tick();
    drive(5'd3, 1, 5'd5, 1, 0, 1, 5'd4, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rs_stall", stall, 1'b0);
    tick();
    check("rs_a_sel", fwd_a_sel, 2'b00);
    check("rs_bubble", ex_bubble, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Generates the 2-bit operand-select codes for the EX-stage ALU operand muxes (sources: register file, EX/MEM result, MEM/WB writeback data, immediate) and the pipeline stall/bubble control for the 5-stage MIPS pipeline. It sits between ID and EX. It tracks the destination registers of in-flight instructions in its own EX/MEM shadow pipeline, and runs a load-use interlock and a multi-cycle mul/div busy counter. Select codes are registered at the ID→EX boundary, so they are valid in the cycle the instruction occupies EX.

## Interface
- MULDIV_LAT, 4: EX-stage occupancy of a mul/div instruction in cycles; valid range 1–15.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs, id_rt  in  5 each  source register numbers.
- id_rs_used, id_rt_used  in  1 each  source is actually read.
- id_b_imm  in  1  operand B is the immediate.
- id_wr_en  in  1  instruction writes a GPR.
- id_wd  in  5  destination register number.
- id_is_load  in  1  instruction is a load.
- id_is_muldiv  in  1  instruction is a mul/div.
- flush  in  1  branch/jump taken; kill the ID instruction.
- fwd_a_sel  out  2  EX operand-A select: 00 regfile, 01 EX/MEM, 10 MEM/WB.
- fwd_b_sel  out  2  EX operand-B select: as A, plus 11 immediate.
- stall  out  1  combinational; freeze PC and IF/ID.
- ex_bubble  out  1  registered; EX holds a bubble this cycle.

## Operation
- Shadow stages EX and MEM each hold {valid, wr_en, wd, is_load}. Each cycle: MEM ← EX, then EX ← ID entry or bubble.
- Hazard match for a source s: s used, s ≠ 0, stage valid, stage wr_en, stage wd == s.
- Register $0 never matches.
- No WB-stage check: the regfile writes in the first half-cycle and reads in the second.
- Load-use: an EX-stage match with EX.is_load asserts stall.
- Mul/div busy: when a mul/div instruction enters EX, busy_cnt loads MULDIV_LAT−1. The counter decrements each cycle while nonzero. stall is asserted while busy_cnt ≠ 0. MULDIV_LAT=1 never stalls.
- stall = id_valid & !flush & (load-use | busy_cnt≠0 | non-forward hazard, see Configuration).
- On stall:
  - EX shadow ← bubble, and ex_bubble=1 next cycle.
  - Selects register 00.
  - The ID instruction is re-evaluated next cycle.
- On flush: EX ← bubble and selects ← 00. Flush wins over stall; stall is forced to 0.
- Otherwise EX ← ID entry with id_valid.
- Select priority for each operand, evaluated in ID and registered into EX:
  - id_b_imm → 11 (B only).
  - EX-stage match → 01.
  - MEM-stage match → 10.
  - Otherwise 00.
- busy_cnt continues counting through flush. A flushed mul/div never loads it.

## Timing
- Reset values: fwd_a_sel=00, fwd_b_sel=00, ex_bubble=1, stall=0, shadow valids=0, busy_cnt=0.
- Reset asserted mid-operation clears all state at the next edge and overrides flush and stall.
- Select latency: one cycle (ID inputs at edge N, outputs valid after edge N).
- stall is combinational from ID inputs and current state, in the same cycle.
- Load-use costs exactly 1 bubble. After the bubble the load is in MEM, and the dependent instruction gets sel 10.
- A mul/div followed by an independent instruction gives MULDIV_LAT−1 stall cycles.
- Back-to-back mul/div: the second one enters EX only when busy_cnt==0.

## Configuration
- FWD_HAZARD_FORWARD_EN defined:
  - Forwarding as above.
  - Only load-use and mul/div busy stall.
- Undefined:
  - fwd_a_sel is always 00. fwd_b_sel is 00 or 11 (immediate).
  - Any EX-stage or MEM-stage match asserts stall until the writer passes MEM. Without a load, that is 2 stall cycles for an EX match and 1 for a MEM match.

## Test plan
- Forwarding from EX: `add $3,$1,$2` then `sub $4,$3,$5` → fwd_a_sel=01 in the cycle after sub enters EX; stall stays 0.
- Forwarding from MEM with priority: `add $3`, then `or $3`, then `and $6,$3,$3`.
  - fwd_a_sel=01 and fwd_b_sel=01 (newest writer wins).
  - With one unrelated instruction between writer and reader: 10.
- Load-use: `lw $7`, then `add $8,$7,$0` → stall=1 for exactly 1 cycle and ex_bubble=1, then fwd_a_sel=10. Destination $0 gives no stall and sel 00.
- Mul/div: MULDIV_LAT=4, `mult` then `add` → stall high 3 cycles. Flush asserted during a stall → stall=0 and the bubble is inserted.
- Immediate and reset:
  - `addi` with id_b_imm=1 matching EX → fwd_b_sel=11.
  - rst during the busy count → busy_cnt=0 and all outputs at reset values next cycle.
- Macro off: `add $3` then `sub $4,$3,$5` → 2 stall cycles, then fwd_a_sel=00.
